// File: rtl/cla_pkg.sv
// Shared definitions for the 8-bit carry-lookahead adder.
//   CLA_WIDTH    : operand width (8)
//   CLA_GROUP    : width of one lookahead group (4)
//   cla_result_t : full result, carry-out in the MSB
package cla_pkg;

  localparam int CLA_WIDTH = 8;
  localparam int CLA_GROUP = 4;

  typedef logic [CLA_WIDTH:0] cla_result_t;

endpackage : cla_pkg

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead group. All internal carries are fully expanded
// sum-of-products terms of the group inputs and ci, so no carry ripples
// from bit to bit inside the group.
//
// Ports:
//   a, b : group operand bits
//   ci   : carry into bit 0 of the group
//   s    : group sum bits
//   gg   : group generate  (group produces a carry on its own)
//   gp   : group propagate (group passes ci straight through)
//   co   : carry out of the group, gg | gp & ci
module cla_4bit
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 gg,
  output logic                 gp,
  output logic                 co
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0]
              | (p[0] & ci);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
  assign co = gg | (gp & ci);

  assign s = p ^ c;

endmodule : cla_4bit

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder with a single registered output stage.
// Two 4-bit lookahead groups are combined by a group-carry unit; the
// result is captured on clk whenever in_valid is high.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears all outputs
//   in_valid  : a/b/cin valid this cycle; result captured at the edge
//   a, b      : unsigned 8-bit operands
//   cin       : carry-in
//   sum       : registered sum bits [7:0]
//   cout      : registered carry-out (bit 8)
//   out       : registered full result, {cout, sum}
//   out_valid : outputs hold a result captured from a valid input
//
// Handshake: in_valid qualifies a/b/cin for one edge only; there is no
// ready, every cycle may carry a new operand set, and out_valid is high
// exactly for the cycle after an accepted input. On an idle cycle the
// data outputs hold and out_valid drops.
module cla_8bit
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [CLA_WIDTH-1:0] sum,
  output logic                 cout,
  output cla_result_t          out,
  output logic                 out_valid
);

  logic [CLA_GROUP-1:0] s_lo;
  logic [CLA_GROUP-1:0] s_hi;
  logic                 gg_lo, gp_lo, gg_hi, gp_hi;
  logic                 c4;
  logic                 cout_c;

  // Each group also produces its own ripple-style co; the top uses the
  // two-level lookahead terms instead, so those outputs go unused here.
  logic                 unused_co_lo;
  logic                 unused_co_hi;

  cla_4bit u_lo (
    .a  (a[CLA_GROUP-1:0]),
    .b  (b[CLA_GROUP-1:0]),
    .ci (cin),
    .s  (s_lo),
    .gg (gg_lo),
    .gp (gp_lo),
    .co (unused_co_lo)
  );

  // Group-carry unit: carry into the high group and final carry-out are
  // both formed directly from group generate/propagate and cin.
  assign c4     = gg_lo | (gp_lo & cin);
  assign cout_c = gg_hi
                | (gp_hi & gg_lo)
                | (gp_hi & gp_lo & cin);

  cla_4bit u_hi (
    .a  (a[CLA_WIDTH-1:CLA_GROUP]),
    .b  (b[CLA_WIDTH-1:CLA_GROUP]),
    .ci (c4),
    .s  (s_hi),
    .gg (gg_hi),
    .gp (gp_hi),
    .co (unused_co_hi)
  );

  // Output register.
  logic [CLA_WIDTH-1:0] sum_d,  sum_q;
  logic                 cout_d, cout_q;
  logic                 out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = {s_hi, s_lo};
      cout_d      = cout_c;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  // Built from the same registers, so out always equals {cout, sum}.
  assign out       = {cout_q, sum_q};
  assign out_valid = out_valid_q;

endmodule : cla_8bit

// File: tb/tb_cla_8bit.sv
// Self-checking bench for cla_8bit: directed arithmetic cases, hold and
// reset behaviour, then a long randomized back-to-back stream compared
// against a plain-arithmetic reference model.
module tb_cla_8bit;
  import cla_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic [7:0]  sum;
  logic        cout;
  cla_result_t out;
  logic        out_valid;

  always #5 clk = ~clk;

  cla_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out       (out),
    .out_valid (out_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
    int total;
    total = int'(x) + int'(y) + int'(c);
    return 9'(total % 512);
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Structural invariant, sampled mid-cycle every cycle.
  logic inv_en = 1'b0;
  always @(negedge clk) begin
    if (inv_en) check("out_eq_cout_sum", out, {cout, sum});
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
  endtask

  // Apply one valid add and check it just after the capturing edge.
  task automatic add_chk(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, input logic [8:0] exp_out);
    drive(1'b1, ta, tb_, tc);
    @(posedge clk);
    #1;
    check({tag, "_out"},  out,              exp_out);
    check({tag, "_sum"},  9'(sum),          9'(exp_out[7:0]));
    check({tag, "_cout"}, 9'(cout),         9'(exp_out[8]));
    check({tag, "_vld"},  9'(out_valid),    9'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"},  9'(sum),       9'd0);
    check({tag, "_cout"}, 9'(cout),      9'd0);
    check({tag, "_out"},  out,           9'd0);
    check({tag, "_vld"},  9'(out_valid), 9'd0);
  endtask

  // Scoreboard: {out_valid, out} expected one cycle after each drive.
  logic [9:0] exp_q[$];

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] last_out;
    logic [7:0] ra, rb;
    logic       rc, rv;
    logic [9:0] e;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset with busy random inputs and a running clock.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk);
    check_zero("reset");
    inv_en = 1'b1;
    rst_n  = 1'b1;

    // Basic adds, no carry-out.
    add_chk("add_0_0_1",     8'd0,   8'd0,   1'b1, 9'd1);
    add_chk("add_14_1_1",    8'd14,  8'd1,   1'b1, 9'd16);
    add_chk("add_5_0_0",     8'd5,   8'd0,   1'b0, 9'd5);
    add_chk("add_99_23_1",   8'd99,  8'd23,  1'b1, 9'd123);
    add_chk("add_120_60_1",  8'd120, 8'd60,  1'b1, 9'd181);
    add_chk("add_127_126_1", 8'd127, 8'd126, 1'b1, 9'd254);

    // Carry-out cases.
    add_chk("co_200_100_0",  8'd200, 8'd100, 1'b0, 9'd300);
    add_chk("co_255_255_1",  8'd255, 8'd255, 1'b1, 9'd511);
    add_chk("co_255_0_1",    8'd255, 8'd0,   1'b1, 9'd256);

    // Lookahead paths.
    add_chk("la_lo_gen",     8'd15,  8'd1,   1'b0, 9'd16);
    add_chk("la_hi_gen",     8'd240, 8'd16,  1'b0, 9'd256);
    add_chk("la_prop",       8'd0,   8'd255, 1'b1, 9'd256);
    add_chk("la_lo_prop_hi", 8'd15,  8'd240, 1'b1, 9'd256);

    // Hold: idle cycles with changing inputs keep the data, drop valid.
    add_chk("hold_setup", 8'd99, 8'd23, 1'b1, 9'd123);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      check("hold_out", out,           9'd123);
      check("hold_vld", 9'(out_valid), 9'd0);
    end

    // Mid-stream reset clears outputs between clock edges.
    add_chk("rst_setup", 8'd200, 8'd100, 1'b0, 9'd300);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    drive(1'b1, 8'd7, 8'd9, 1'b1);
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post_rst_vld", 9'(out_valid), 9'd0);
    add_chk("post_rst_add", 8'd5, 8'd0, 1'b0, 9'd5);

    // Randomized back-to-back stream against the reference model.
    last_out = 9'd5;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_out", out,           e[8:0]);
        check("rnd_vld", 9'(out_valid), 9'(e[9]));
      end
      case ($urandom_range(0, 7))
        0:       ra = 8'hFF;
        1:       ra = 8'h00;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 8'hFF;
        1:       rb = ~ra;
        default: rb = 8'($urandom);
      endcase
      rc = 1'($urandom);
      rv = ($urandom_range(0, 7) != 0);
      in_valid = rv;
      a        = ra;
      b        = rb;
      cin      = rc;
      if (rv) last_out = ref_add(ra, rb, rc);
      exp_q.push_back({rv, last_out});
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rnd_out", out,           e[8:0]);
      check("rnd_vld", 9'(out_valid), 9'(e[9]));
    end

    inv_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_8bit
